// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO write-side blocks: default sizes, arbiter
// state encoding and Gray/binary pointer conversion helpers.
package fifo_pkg;

    localparam int FIFO_DSIZE = 8;
    localparam int FIFO_ASIZE = 4;

    // Pointer helpers are sized generously so any supported ASIZE fits;
    // callers zero-extend their ASIZE+1 bit pointer and truncate the result.
    localparam int PTR_MAX_W = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } arb_state_t;

    function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g);
        logic [PTR_MAX_W-1:0] b;
        b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
        for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after 'start',
// wrapping modulo N.
module rr_pick #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    output logic [N-1:0]  win_onehot,
    output logic [IW-1:0] win_idx,
    output logic          valid
);

    // Scan from lowest to highest priority so the highest-priority hit wins last.
    always_comb begin
        int s;
        s          = 0;
        win_onehot = '0;
        win_idx    = '0;
        valid      = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            s = int'(start) + k;
            if (s >= N) begin
                s = s - N;
            end
            if (req[s]) begin
                win_onehot    = '0;
                win_onehot[s] = 1'b1;
                win_idx       = IW'(s);
                valid         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// FIFO write-side controller: round-robin arbitration of NREQ producers with
// bounded burst ownership, memory write port drive, Gray write pointer and
// full / almost-full flags derived from the synchronized read pointer.
module fifo_wr_arbiter
    import fifo_pkg::*;
#(
    parameter int DSIZE     = FIFO_DSIZE,
    parameter int ASIZE     = FIFO_ASIZE,
    parameter int NREQ      = 4,
    parameter int BURST_LEN = 4,
    parameter int AF_MARGIN = 2
) (
    input  logic                  wclk,
    input  logic                  wrst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*DSIZE-1:0] req_data,
    output logic [NREQ-1:0]       gnt,
    input  logic [ASIZE:0]        wq2_rptr,
    output logic                  wclken,
    output logic [ASIZE-1:0]      waddr,
    output logic [DSIZE-1:0]      wdata,
    output logic [ASIZE:0]        wptr,
    output logic                  wfull,
    output logic                  walmost_full
);

    localparam int PTR_W = ASIZE + 1;
    localparam int DEPTH = 1 << ASIZE;
    localparam int IW    = $clog2(NREQ);
    localparam int CNT_W = $clog2(BURST_LEN + 1);

    arb_state_t       state_reg, state_next;
    logic [IW-1:0]    owner_reg, owner_next;
    logic [IW-1:0]    rr_reg, rr_next;
    logic [CNT_W-1:0] burst_reg, burst_next;
    logic [PTR_W-1:0] wbin_reg;
    logic [PTR_W-1:0] wptr_reg;
    logic             wfull_reg;
    logic             walmost_full_reg;

    logic [PTR_W-1:0] wbin_next;
    logic [PTR_W-1:0] wgray_next;
    logic [PTR_W-1:0] rbin;
    logic [PTR_W-1:0] count;
    logic [PTR_W:0]   free_slots;
    logic             wfull_next;
    logic             walmost_full_next;

    logic [IW-1:0]    pick_start;
    logic [NREQ-1:0]  pick_onehot;
    logic [IW-1:0]    pick_idx;
    logic             pick_valid;
    logic [NREQ-1:0]  owner_onehot;
    logic [DSIZE-1:0] slice [NREQ];

    function automatic logic [IW-1:0] inc_mod(input logic [IW-1:0] i);
        if (i == IW'(NREQ - 1)) begin
            return '0;
        end
        return i + 1'b1;
    endfunction

    // While owning, the old owner drops to lowest priority on re-arbitration.
    assign pick_start   = (state_reg == ST_OWN) ? inc_mod(owner_reg) : rr_reg;
    assign owner_onehot = NREQ'(1) << owner_reg;

    rr_pick #(.N(NREQ)) u_pick (
        .req       (req),
        .start     (pick_start),
        .win_onehot(pick_onehot),
        .win_idx   (pick_idx),
        .valid     (pick_valid)
    );

    // Arbiter next state and grant; grant is held low while reset is asserted.
    always_comb begin
        state_next = state_reg;
        owner_next = owner_reg;
        burst_next = burst_reg;
        rr_next    = rr_reg;
        gnt        = '0;
        if (wrst_n && !wfull_reg) begin
            case (state_reg)
                ST_IDLE: begin
                    if (pick_valid) begin
                        gnt        = pick_onehot;
                        owner_next = pick_idx;
                        burst_next = CNT_W'(1);
                        if (BURST_LEN > 1) begin
                            state_next = ST_OWN;
                        end else begin
                            rr_next = inc_mod(pick_idx);
                        end
                    end
                end
                ST_OWN: begin
                    if (req[owner_reg] && (burst_reg < CNT_W'(BURST_LEN))) begin
                        gnt        = owner_onehot;
                        burst_next = burst_reg + 1'b1;
                    end else if (pick_valid) begin
                        gnt        = pick_onehot;
                        owner_next = pick_idx;
                        burst_next = CNT_W'(1);
                        rr_next    = inc_mod(pick_idx);
                    end else begin
                        state_next = ST_IDLE;
                        rr_next    = inc_mod(owner_reg);
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
        assign slice[gi] = req_data[gi*DSIZE +: DSIZE];
    end

    // Write data is the granted requester's slice, zero when nothing is granted.
    always_comb begin
        wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                wdata = wdata | slice[i];
            end
        end
    end

    assign wclken = |gnt;
    assign waddr  = wbin_reg[ASIZE-1:0];

    // Pointer advance and flag computation against the synchronized read pointer.
    always_comb begin
        wbin_next         = wbin_reg + PTR_W'(wclken);
        wgray_next        = PTR_W'(bin2gray(PTR_MAX_W'(wbin_next)));
        rbin              = PTR_W'(gray2bin(PTR_MAX_W'(wq2_rptr)));
        count             = wbin_next - rbin;
        free_slots        = (PTR_W + 1)'(DEPTH) - {1'b0, count};
        wfull_next        = (wgray_next == {~wq2_rptr[ASIZE:ASIZE-1], wq2_rptr[ASIZE-2:0]});
        walmost_full_next = (free_slots <= (PTR_W + 1)'(AF_MARGIN));
    end

    // State, pointer and flag registers.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state_reg        <= ST_IDLE;
            owner_reg        <= '0;
            rr_reg           <= '0;
            burst_reg        <= '0;
            wbin_reg         <= '0;
            wptr_reg         <= '0;
            wfull_reg        <= 1'b0;
            walmost_full_reg <= 1'b0;
        end else begin
            state_reg        <= state_next;
            owner_reg        <= owner_next;
            rr_reg           <= rr_next;
            burst_reg        <= burst_next;
            wbin_reg         <= wbin_next;
            wptr_reg         <= wgray_next;
            wfull_reg        <= wfull_next;
            walmost_full_reg <= walmost_full_next;
        end
    end

    assign wptr         = wptr_reg;
    assign wfull        = wfull_reg;
    assign walmost_full = walmost_full_reg;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter with a transaction-level reference
// model (owner / run length / write and read counts as plain integers).
module tb_fifo_wr_arbiter;

    localparam int DSIZE = 8;
    localparam int ASIZE = 4;
    localparam int NREQ  = 4;
    localparam int BURST = 4;
    localparam int AFM   = 2;
    localparam int DEPTH = 16;

    logic        wclk = 1'b0;
    logic        wrst_n = 1'b0;
    logic [3:0]  req = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  gnt;
    logic [4:0]  wq2_rptr = '0;
    logic        wclken;
    logic [3:0]  waddr;
    logic [7:0]  wdata;
    logic [4:0]  wptr;
    logic        wfull;
    logic        walmost_full;

    int checks = 0;
    int errors = 0;

    fifo_wr_arbiter #(
        .DSIZE(DSIZE), .ASIZE(ASIZE), .NREQ(NREQ), .BURST_LEN(BURST), .AF_MARGIN(AFM)
    ) dut (
        .wclk        (wclk),
        .wrst_n      (wrst_n),
        .req         (req),
        .req_data    (req_data),
        .gnt         (gnt),
        .wq2_rptr    (wq2_rptr),
        .wclken      (wclken),
        .waddr       (waddr),
        .wdata       (wdata),
        .wptr        (wptr),
        .wfull       (wfull),
        .walmost_full(walmost_full)
    );

    always #5 wclk = ~wclk;

    // ---------------- reference model ----------------
    int m_owner, m_run, m_pri, m_wcount, m_rcount;
    bit m_full, m_af;
    int e_owner, e_run, e_pri, e_gidx;
    logic [16:0] exp_comb;   // {gnt, wclken, waddr, wdata}
    logic [6:0]  exp_regs;   // {wptr, wfull, walmost_full}

    function automatic logic [4:0] gray5(input int b);
        logic [4:0] v;
        v = 5'(b % 32);
        return v ^ (v >> 1);
    endfunction

    function automatic int m_pick(input int start, input logic [3:0] r);
        for (int k = 0; k < NREQ; k++) begin
            if (r[(start + k) % NREQ]) return (start + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner  = -1;
        m_run    = 0;
        m_pri    = 0;
        m_wcount = 0;
        m_full   = 0;
        m_af     = 0;
    endtask

    task automatic model_eval();
        int st, w;
        logic [3:0] eg;
        logic [7:0] ed;
        e_owner = m_owner;
        e_run   = m_run;
        e_pri   = m_pri;
        e_gidx  = -1;
        if (!m_full) begin
            if (m_owner >= 0 && req[m_owner] && m_run < BURST) begin
                e_gidx = m_owner;
                e_run  = m_run + 1;
            end else begin
                st = (m_owner >= 0) ? (m_owner + 1) % NREQ : m_pri;
                w  = m_pick(st, req);
                if (w >= 0) begin
                    e_gidx = w;
                    e_run  = 1;
                    if (BURST > 1) e_owner = w;
                    else begin
                        e_owner = -1;
                        e_pri   = (w + 1) % NREQ;
                    end
                    if (m_owner >= 0) e_pri = (w + 1) % NREQ;
                end else if (m_owner >= 0) begin
                    e_pri   = (m_owner + 1) % NREQ;
                    e_owner = -1;
                end
            end
        end
        eg = '0;
        ed = '0;
        if (e_gidx >= 0) begin
            eg[e_gidx] = 1'b1;
            ed = req_data[e_gidx*DSIZE +: DSIZE];
        end
        exp_comb = {eg, (e_gidx >= 0), 4'(m_wcount % DEPTH), ed};
    endtask

    task automatic model_commit();
        int occ;
        m_owner = e_owner;
        m_run   = e_run;
        m_pri   = e_pri;
        if (e_gidx >= 0) begin
            $display("wr req%0d addr %0d data %02h", e_gidx, m_wcount % DEPTH, exp_comb[7:0]);
            m_wcount++;
        end
        occ      = m_wcount - m_rcount;
        m_full   = (occ == DEPTH);
        m_af     = ((DEPTH - occ) <= AFM);
        exp_regs = {gray5(m_wcount), m_full, m_af};
    endtask

    task automatic step_pre();
        wq2_rptr = gray5(m_rcount);
        #1;
        model_eval();
    endtask

    task automatic step_edge();
        @(posedge wclk);
        model_commit();
        #1;
    endtask

    task automatic do_reset();
        @(negedge wclk);
        wrst_n   = 1'b0;
        req      = '0;
        m_rcount = 0;
        wq2_rptr = '0;
        model_reset();
        repeat (2) @(negedge wclk);
        wrst_n = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        wrst_n   = 1'b0;
        req      = 4'b1111;
        req_data = $urandom;
        m_rcount = 0;
        model_reset();
        for (int c = 0; c < 3; c++) begin
            @(posedge wclk);
            #1;
            checks++;
            if ({gnt, wclken, waddr, wptr, wfull, walmost_full} !== 16'h0) begin
                errors++;
                $display("FAIL reset_hold cyc %0d got gnt=%b en=%b addr=%0d wptr=%b full=%b af=%b want all 0",
                         c, gnt, wclken, waddr, wptr, wfull, walmost_full);
            end
            req = ~req;
        end
        @(negedge wclk);
        req    = 4'b1111;
        wrst_n = 1'b1;
        step_pre();
        checks++;
        if (gnt !== 4'b0001 || gnt !== exp_comb[16:13]) begin
            errors++;
            $display("FAIL reset_first_gnt got %b want 0001", gnt);
        end
        step_edge();
        checks++;
        if ({wptr, wfull, walmost_full} !== exp_regs) begin
            errors++;
            $display("FAIL reset_first_regs got %b want %b", {wptr, wfull, walmost_full}, exp_regs);
        end
        @(negedge wclk);
    endtask

    task automatic test_burst_limit();
        int seq [12] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0};
        logic [3:0] want;
        do_reset();
        req = 4'b0011;
        for (int c = 0; c < 12; c++) begin
            req_data = $urandom;
            step_pre();
            want = 4'(1 << seq[c]);
            checks++;
            if ({gnt, wclken, waddr, wdata} !== exp_comb || gnt !== want || waddr !== 4'(c)) begin
                errors++;
                $display("FAIL burst_comb cyc %0d got %h (gnt %b addr %0d) want %h (gnt %b addr %0d)",
                         c, {gnt, wclken, waddr, wdata}, gnt, waddr, exp_comb, want, c);
            end
            step_edge();
            checks++;
            if ({wptr, wfull, walmost_full} !== exp_regs) begin
                errors++;
                $display("FAIL burst_regs cyc %0d got %b want %b", c, {wptr, wfull, walmost_full}, exp_regs);
            end
            @(negedge wclk);
        end
    endtask

    task automatic test_early_release();
        logic [3:0] req_t [6] = '{4'b0101, 4'b0101, 4'b0100, 4'b0100, 4'b0000, 4'b1111};
        logic [3:0] gnt_t [6] = '{4'b0001, 4'b0001, 4'b0100, 4'b0100, 4'b0000, 4'b1000};
        do_reset();
        for (int c = 0; c < 6; c++) begin
            req      = req_t[c];
            req_data = $urandom;
            step_pre();
            checks++;
            if ({gnt, wclken, waddr, wdata} !== exp_comb || gnt !== gnt_t[c]) begin
                errors++;
                $display("FAIL early_comb cyc %0d got %h (gnt %b) want %h (gnt %b)",
                         c, {gnt, wclken, waddr, wdata}, gnt, exp_comb, gnt_t[c]);
            end
            step_edge();
            checks++;
            if ({wptr, wfull, walmost_full} !== exp_regs) begin
                errors++;
                $display("FAIL early_regs cyc %0d got %b want %b", c, {wptr, wfull, walmost_full}, exp_regs);
            end
            @(negedge wclk);
        end
    endtask

    task automatic test_fill_full();
        do_reset();
        req = 4'b0001;
        for (int c = 0; c < 20; c++) begin
            req_data = $urandom;
            step_pre();
            checks++;
            if ({gnt, wclken, waddr, wdata} !== exp_comb) begin
                errors++;
                $display("FAIL fill_comb cyc %0d got %h want %h", c, {gnt, wclken, waddr, wdata}, exp_comb);
            end
            step_edge();
            checks++;
            if ({wptr, wfull, walmost_full} !== exp_regs) begin
                errors++;
                $display("FAIL fill_regs cyc %0d got %b want %b", c, {wptr, wfull, walmost_full}, exp_regs);
            end
            if (c == 12 || c == 13) begin
                checks++;
                if (walmost_full !== (c == 13)) begin
                    errors++;
                    $display("FAIL fill_af after %0d writes got %b want %b", c + 1, walmost_full, (c == 13));
                end
            end
            if (c == 15) begin
                checks++;
                if (wfull !== 1'b1 || wptr !== 5'b11000) begin
                    errors++;
                    $display("FAIL fill_full got full=%b wptr=%b want full=1 wptr=11000", wfull, wptr);
                end
            end
            @(negedge wclk);
        end
    endtask

    task automatic test_drain_while_full();
        int ngrants = 0;
        m_rcount = 1;
        for (int c = 0; c < 4; c++) begin
            req_data = $urandom;
            step_pre();
            checks++;
            if ({gnt, wclken, waddr, wdata} !== exp_comb) begin
                errors++;
                $display("FAIL drain_comb cyc %0d got %h want %h", c, {gnt, wclken, waddr, wdata}, exp_comb);
            end
            if (wclken === 1'b1) begin
                ngrants++;
                checks++;
                if (waddr !== 4'd0 || c != 1) begin
                    errors++;
                    $display("FAIL drain_addr cyc %0d got addr %0d want addr 0 at cyc 1", c, waddr);
                end
            end
            step_edge();
            checks++;
            if ({wptr, wfull, walmost_full} !== exp_regs) begin
                errors++;
                $display("FAIL drain_regs cyc %0d got %b want %b", c, {wptr, wfull, walmost_full}, exp_regs);
            end
            @(negedge wclk);
        end
        checks++;
        if (ngrants != 1) begin
            errors++;
            $display("FAIL drain_count got %0d writes want 1", ngrants);
        end
    endtask

    task automatic test_wrap();
        int hist[$];
        do_reset();
        for (int c = 0; c < 40; c++) begin
            hist.push_back(m_wcount);
            if (hist.size() >= 3) m_rcount = hist[hist.size() - 3];
            req      = 4'($urandom_range(1, 15));
            req_data = $urandom;
            step_pre();
            checks++;
            if ({gnt, wclken, waddr, wdata} !== exp_comb) begin
                errors++;
                $display("FAIL wrap_comb cyc %0d got %h want %h", c, {gnt, wclken, waddr, wdata}, exp_comb);
            end
            step_edge();
            checks++;
            if ({wptr, wfull, walmost_full} !== exp_regs || wfull !== 1'b0) begin
                errors++;
                $display("FAIL wrap_regs cyc %0d got %b want %b", c, {wptr, wfull, walmost_full}, exp_regs);
            end
            @(negedge wclk);
        end
    endtask

    task automatic test_reset_midburst();
        do_reset();
        req = 4'b0001;
        for (int c = 0; c < 2; c++) begin
            req_data = $urandom;
            step_pre();
            checks++;
            if ({gnt, wclken, waddr, wdata} !== exp_comb) begin
                errors++;
                $display("FAIL midrst_comb cyc %0d got %h want %h", c, {gnt, wclken, waddr, wdata}, exp_comb);
            end
            step_edge();
            @(negedge wclk);
        end
        #2;
        wrst_n = 1'b0;
        model_reset();
        m_rcount = 0;
        #1;
        checks++;
        if ({gnt, wclken, waddr, wptr, wfull, walmost_full} !== 16'h0) begin
            errors++;
            $display("FAIL midrst_async got gnt=%b en=%b addr=%0d wptr=%b full=%b af=%b want all 0",
                     gnt, wclken, waddr, wptr, wfull, walmost_full);
        end
        @(posedge wclk);
        @(negedge wclk);
        wrst_n = 1'b1;
        step_pre();
        checks++;
        if ({gnt, wclken, waddr, wdata} !== exp_comb || waddr !== 4'd0) begin
            errors++;
            $display("FAIL midrst_resume got %h want %h", {gnt, wclken, waddr, wdata}, exp_comb);
        end
        step_edge();
        @(negedge wclk);
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 300; c++) begin
            if ($urandom_range(0, 2) == 0 && m_rcount < m_wcount) m_rcount++;
            req      = 4'($urandom_range(0, 15));
            req_data = $urandom;
            step_pre();
            checks++;
            if ({gnt, wclken, waddr, wdata} !== exp_comb) begin
                errors++;
                $display("FAIL rand_comb cyc %0d got %h want %h", c, {gnt, wclken, waddr, wdata}, exp_comb);
            end
            step_edge();
            checks++;
            if ({wptr, wfull, walmost_full} !== exp_regs) begin
                errors++;
                $display("FAIL rand_regs cyc %0d got %b want %b", c, {wptr, wfull, walmost_full}, exp_regs);
            end
            @(negedge wclk);
        end
    endtask

    initial begin
        test_reset();
        test_burst_limit();
        test_early_release();
        test_fill_full();
        test_drain_while_full();
        test_wrap();
        test_reset_midburst();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
